// File: rtl/syndrome_frame_ctrl.sv
// syndrome_frame_ctrl: frames incoming codeword beats for a bank of J
// syndrome lanes and buffers the J syndromes each lane bank produces.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_valid_i/in_sof_i upstream beat valid / beat is codeword beat 0
//   in_ready_o          beat accepted when in_valid_i && in_ready_o
//   lane_valid_o        beat valid to all lanes (combinational)
//   lane_start_o        codeword start to the lanes (combinational)
//   lane_last_o         codeword last beat to the lanes (combinational)
//   lane_s_valid_i      syndrome-valid from lane 1 (registered in the lane)
//   lane_s_i            J x 10-bit lane syndromes, lane j at [10j-1:10(j-1)]
//   out_valid_o         syndrome buffer holds a frame
//   out_ready_i         downstream accepts the buffer
//   syn_o               buffered syndromes
//   err_free_o          all buffered syndromes are zero
//   abort_o             one-cycle pulse: frame restarted mid-codeword
//
// Build option: define SYND_CTRL_ERRFREE_EN to build the zero detector
// behind err_free_o; otherwise err_free_o is tied low.

module syndrome_frame_ctrl #(
    parameter int unsigned M    = 32,
    parameter int unsigned NSYM = 544,
    parameter int unsigned J    = 22
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    input  logic            in_sof_i,
    output logic            in_ready_o,
    output logic            lane_valid_o,
    output logic            lane_start_o,
    output logic            lane_last_o,
    input  logic            lane_s_valid_i,
    input  logic [J*10-1:0] lane_s_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [J*10-1:0] syn_o,
    output logic            err_free_o,
    output logic            abort_o
);

    localparam int unsigned BEATS  = NSYM / M;
    localparam int unsigned CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SW     = J * 10;
    localparam bit          SINGLE = (BEATS == 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // Elaboration-time parameter sanity check
    if (NSYM % M != 0) begin : g_bad_nsym
        $error("syndrome_frame_ctrl: NSYM must be a multiple of M");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic            pend_q;
    logic            abort_q, abort_d;
    logic            out_valid_q;
    logic [SW-1:0]   syn_q;
    logic            last_cand;
    logic            acc;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            abort_q <= abort_d;
        end
    end

    // Next state, beat handshake and lane controls
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        abort_d      = 1'b0;
        lane_valid_o = 1'b0;
        lane_start_o = 1'b0;
        lane_last_o  = 1'b0;
        in_ready_o   = 1'b1;
        acc          = 1'b0;

        // Would this beat be a codeword's last beat if accepted?
        if (in_sof_i) begin
            last_cand = in_valid_i && SINGLE;
        end else begin
            last_cand = in_valid_i && (state_q == RUN) && (beat_q == LAST_BEAT);
        end

        // Hold the last beat while its capture could overwrite unconsumed data
        if (last_cand && ((out_valid_q && !out_ready_i) || pend_q)) begin
            in_ready_o = 1'b0;
        end

        acc         = in_valid_i && in_ready_o;
        lane_last_o = acc && last_cand;

        if (acc) begin
            if (in_sof_i) begin
                lane_valid_o = 1'b1;
                lane_start_o = 1'b1;
                abort_d      = (state_q == RUN);
                if (SINGLE) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    state_d = RUN;
                    beat_d  = CW'(1);
                end
            end else if (state_q == RUN) begin
                lane_valid_o = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
        end
    end

    // A last beat went to the lanes and its syndromes have not arrived yet
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
        end else if (lane_last_o) begin
            pend_q <= 1'b1;
        end else if (lane_s_valid_i) begin
            pend_q <= 1'b0;
        end
    end

    // Syndrome buffer; a capture wins over a same-edge drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            syn_q       <= '0;
        end else if (lane_s_valid_i) begin
            out_valid_q <= 1'b1;
            syn_q       <= lane_s_i;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef SYND_CTRL_ERRFREE_EN
    logic err_free_q;

    // Zero detect over the captured syndromes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_free_q <= 1'b0;
        end else if (lane_s_valid_i) begin
            err_free_q <= ~|lane_s_i;
        end
    end

    assign err_free_o = err_free_q;
`else
    assign err_free_o = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign syn_o       = syn_q;
    assign abort_o     = abort_q;

endmodule

// File: tb/tb_syndrome_frame_ctrl.sv
// Randomized self-checking bench for syndrome_frame_ctrl (default parameters).
// The bench also plays lane 1: it raises lane_s_valid_i one cycle after the
// lanes see a last beat.

module tb_syndrome_frame_ctrl;

    localparam int BEATS = 17;
    localparam int SW    = 220;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_sof_i = 1'b0;
    logic          in_ready_o;
    logic          lane_valid_o;
    logic          lane_start_o;
    logic          lane_last_o;
    logic          lane_s_valid_i = 1'b0;
    logic [SW-1:0] lane_s_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [SW-1:0] syn_o;
    logic          err_free_o;
    logic          abort_o;

    syndrome_frame_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_sof_i       (in_sof_i),
        .in_ready_o     (in_ready_o),
        .lane_valid_o   (lane_valid_o),
        .lane_start_o   (lane_start_o),
        .lane_last_o    (lane_last_o),
        .lane_s_valid_i (lane_s_valid_i),
        .lane_s_i       (lane_s_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .syn_o          (syn_o),
        .err_free_o     (err_free_o),
        .abort_o        (abort_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position inside the open codeword (0 = no frame open)
    int            m_pos = 0;
    bit            m_ov = 1'b0;
    logic [SW-1:0] m_syn = '0;
    bit            m_err = 1'b0;
    bit            m_abort = 1'b0;
    bit            lane_sv = 1'b0;   // bench lane: syndromes ready next cycle
    logic [SW-1:0] lane_s = '0;
    int            n_capt = 0;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("out_valid", SW'(out_valid_o), SW'(m_ov));
        check("syn", syn_o, m_syn);
        check("err_free", SW'(err_free_o), SW'(m_err));
        check("abort", SW'(abort_o), SW'(m_abort));
    endtask

    // One clock cycle of stimulus, checked against the model
    task automatic step(input bit v, input bit sof, input bit ordy, output bit acc_o);
        bit last_cand, e_rdy, e_acc, e_lv, e_start, e_last;
        @(negedge clk_i);
        in_valid_i     = v;
        in_sof_i       = sof;
        out_ready_i    = ordy;
        lane_s_valid_i = lane_sv;
        lane_s_i       = lane_s;
        #1;
        // Beat index if accepted: sof is always beat 0; otherwise m_pos
        last_cand = v && (sof ? (BEATS == 1) : (m_pos != 0 && m_pos == BEATS - 1));
        e_rdy   = !(last_cand && ((m_ov && !ordy) || lane_sv));
        e_acc   = v && e_rdy;
        e_lv    = e_acc && (sof || m_pos != 0);
        e_start = e_acc && sof;
        e_last  = e_acc && last_cand;
        check("in_ready", SW'(in_ready_o), SW'(e_rdy));
        check("lane_valid", SW'(lane_valid_o), SW'(e_lv));
        check("lane_start", SW'(lane_start_o), SW'(e_start));
        check("lane_last", SW'(lane_last_o), SW'(e_last));
        check_regs();
        @(posedge clk_i);
        if (lane_sv) begin
            m_syn = lane_s;
            m_ov  = 1'b1;
`ifdef SYND_CTRL_ERRFREE_EN
            m_err = (lane_s == '0);
`else
            m_err = 1'b0;
`endif
            n_capt++;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        m_abort = e_acc && sof && (m_pos != 0);
        lane_sv = e_last;
        if (e_acc) begin
            if (sof)             m_pos = (BEATS == 1) ? 0 : 1;
            else if (m_pos != 0) m_pos = (m_pos + 1 == BEATS) ? 0 : m_pos + 1;
        end
        acc_o = e_acc;
    endtask

    // Offer one beat until it is accepted, with a bounded wait
    task automatic beat(input bit sof, input bit ordy);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) step(1'b1, sof, ordy, a);
        if (!a) check("beat_timeout", SW'(0), SW'(1));
    endtask

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ordy, a);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni         = 1'b0;
        in_valid_i     = 1'b0;
        in_sof_i       = 1'b0;
        lane_s_valid_i = 1'b0;
        m_pos = 0; m_ov = 1'b0; m_syn = '0; m_err = 1'b0; m_abort = 1'b0; lane_sv = 1'b0;
        #1;
        check_regs();
        check("rst_in_ready", SW'(in_ready_o), SW'(1));
        check("rst_lane_valid", SW'(lane_valid_o), SW'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    function automatic logic [SW-1:0] rand_syn();
        logic [SW-1:0] r;
        for (int i = 0; i < SW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        bit a;
        int capt0;
        do_reset();

        // Full zero-syndrome frame
        lane_s = '0;
        beat(1'b1, 1'b1);
        for (int i = 1; i < BEATS; i++) beat(1'b0, 1'b1);
        idle(3, 1'b0);

        // Lane 3 syndrome only, drained at once
        lane_s = '0;
        lane_s[29:20] = 10'h2A5;
        beat(1'b1, 1'b1);
        for (int i = 1; i < BEATS; i++) beat(1'b0, 1'b1);
        idle(3, 1'b1);
        check("syn_lane3", SW'(syn_o[29:20]), SW'(10'h2A5));

        // Buffer full while the next frame reaches its last beat
        lane_s = rand_syn();
        beat(1'b1, 1'b0);
        for (int i = 1; i < BEATS; i++) beat(1'b0, 1'b0);
        idle(3, 1'b0);
        lane_s = rand_syn();
        beat(1'b1, 1'b0);
        for (int i = 1; i < BEATS - 1; i++) beat(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, a);
        beat(1'b0, 1'b1);
        idle(4, 1'b0);

        // Restart at beat 9, then complete; exactly one capture
        capt0 = n_capt;
        lane_s = rand_syn();
        beat(1'b1, 1'b1);
        for (int i = 1; i < 9; i++) beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        for (int i = 1; i < BEATS; i++) beat(1'b0, 1'b1);
        idle(4, 1'b1);
        check("abort_one_capture", SW'(n_capt - capt0), SW'(1));

        // Beats without sof from idle are discarded
        capt0 = n_capt;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, a);
        idle(3, 1'b1);
        check("nosof_no_capture", SW'(n_capt - capt0), SW'(0));

        // Reset mid-frame, then a complete new frame
        lane_s = rand_syn();
        beat(1'b1, 1'b0);
        for (int i = 1; i < 8; i++) beat(1'b0, 1'b0);
        do_reset();
        lane_s = rand_syn();
        beat(1'b1, 1'b0);
        for (int i = 1; i < BEATS; i++) beat(1'b0, 1'b0);
        idle(3, 1'b0);
        check("post_reset_syn", syn_o, lane_s);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0)
                lane_s = ($urandom_range(0, 3) == 0) ? '0 : rand_syn();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
